// File: rtl/logicnet_argmax_decoder_pkg.sv
// Shared logicnet definitions: argmax decoder FSM states and default sizing.
package logicnet_argmax_decoder_pkg;

  localparam int LN_NUM_CLASSES = 5;
  localparam int LN_SCORE_W     = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } argmax_state_e;

endpackage

// File: rtl/logicnet_argmax_decoder.sv
// Serial argmax over a registered vector of quantized class scores; one class per cycle.
// Handshakes: a transfer happens on a rising edge where valid&ready are both 1; valid never waits on ready.
module logicnet_argmax_decoder
  import logicnet_argmax_decoder_pkg::*;
#(
  parameter int NUM_CLASSES = LN_NUM_CLASSES,
  parameter int SCORE_W     = LN_SCORE_W,
  parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_CLASSES*SCORE_W-1:0] in_scores,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [IDX_W-1:0]               out_class,
  output logic [SCORE_W-1:0]             out_score,
  output logic                           out_tie,
  output logic [1:0]                     dbg_state
);

  // One extra bit so the counter cannot wrap when NUM_CLASSES is a power of two.
  localparam int CNT_W = IDX_W + 1;

  argmax_state_e                  state_q, state_d;
  logic [NUM_CLASSES*SCORE_W-1:0] scores_q;
  logic [SCORE_W-1:0]             best_q, best_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [CNT_W-1:0]               cnt_q;
  logic                           tie_q, tie_d;
  logic [SCORE_W-1:0]             cur_score;
  logic                           last_scan;
  logic                           accept;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign dbg_state = state_q;
  assign accept    = in_valid && in_ready;
  assign last_scan = (cnt_q == CNT_W'(NUM_CLASSES - 1));

  always_comb begin
    cur_score = '0;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      if (cnt_q == CNT_W'(k)) cur_score = scores_q[k*SCORE_W +: SCORE_W];
    end
  end

  // Strict greater-than keeps the lowest index on equal scores.
  always_comb begin
    best_d = best_q;
    idx_d  = idx_q;
    tie_d  = tie_q;
    if (cur_score > best_q) begin
      best_d = cur_score;
      idx_d  = cnt_q[IDX_W-1:0];
      tie_d  = 1'b0;
    end else if (cur_score == best_q) begin
      tie_d  = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_SCAN;
      ST_SCAN: if (last_scan) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      scores_q  <= '0;
      best_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      tie_q     <= 1'b0;
      out_class <= '0;
      out_score <= '0;
      out_tie   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && accept) begin
        scores_q <= in_scores;
        best_q   <= in_scores[SCORE_W-1:0];
        idx_q    <= '0;
        cnt_q    <= CNT_W'(1);
        tie_q    <= 1'b0;
      end else if (state_q == ST_SCAN) begin
        best_q <= best_d;
        idx_q  <= idx_d;
        tie_q  <= tie_d;
        cnt_q  <= cnt_q + CNT_W'(1);
        // Result registers change only here, so they hold through IDLE, SCAN and a stalled DONE.
        if (last_scan) begin
          out_class <= idx_d;
          out_score <= best_d;
          out_tie   <= tie_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_logicnet_argmax_decoder.sv
// Bench for logicnet_argmax_decoder: directed vectors, transaction-level model, per-cycle compare.
module tb_logicnet_argmax_decoder;
  import logicnet_argmax_decoder_pkg::*;

  localparam int N  = 5;
  localparam int SW = 2;
  localparam int IW = $clog2(N);
  localparam int RW = IW + SW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N*SW-1:0] in_scores;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_class;
  logic [SW-1:0] out_score;
  logic          out_tie;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] last_res = '0;
  int acc_cyc  = 0;
  int prev_acc = -1;
  bit b2b_chk  = 1'b0;

  logicnet_argmax_decoder #(.NUM_CLASSES(N), .SCORE_W(SW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_scores(in_scores),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .out_score(out_score), .out_tie(out_tie),
    .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*SW-1:0] pack5(input int c0, c1, c2, c3, c4);
    logic [N*SW-1:0] v;
    v = {SW'(c4), SW'(c3), SW'(c2), SW'(c1), SW'(c0)};
    return v;
  endfunction

  // Argmax as max-then-first-index, tie as "more than one class holds the max".
  function automatic logic [RW-1:0] model(input logic [N*SW-1:0] v);
    int best = -1;
    int cls  = 0;
    int nmax = 0;
    for (int k = 0; k < N; k++) begin
      if (int'(v[k*SW +: SW]) > best) begin
        best = int'(v[k*SW +: SW]);
        cls  = k;
      end
    end
    for (int k = 0; k < N; k++) if (int'(v[k*SW +: SW]) == best) nmax++;
    return {IW'(cls), SW'(best), (nmax > 1)};
  endfunction

  // Scoreboard / per-cycle compare
  always @(negedge clk) begin
    bit exp_valid;
    if (rst) begin
      exp_q.delete();
      last_res = '0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_outputs", {out_class, out_score, out_tie}, 0);
    end else begin
      exp_valid = (exp_q.size() > 0) && (cyc - acc_cyc + 1 >= N);
      chk("in_ready", in_ready, exp_q.size() == 0);
      chk("out_valid", out_valid, exp_valid);
      if (exp_valid) chk("result", {out_class, out_score, out_tie}, exp_q[0]);
      else           chk("held_result", {out_class, out_score, out_tie}, last_res);
      if (exp_valid && out_ready) begin
        last_res = exp_q.pop_front();
      end else if (exp_q.size() == 0 && in_valid) begin
        exp_q.push_back(model(in_scores));
        acc_cyc = cyc + 1;
        if (b2b_chk && prev_acc >= 0) chk("accept_spacing", acc_cyc - prev_acc, N + 1);
        prev_acc = acc_cyc;
      end
    end
  end

  // Driver tasks
  task automatic send(input logic [N*SW-1:0] v);
    int budget = 50;
    in_scores = v;
    in_valid  = 1'b1;
    while (!in_ready && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    chk("accept_wait", budget > 0, 1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_scores = N*SW'($urandom);
  endtask

  task automatic expect_result(input int c, input int s, input int t, input int hold);
    int budget = 50;
    while (!out_valid && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    chk("result_wait", budget > 0, 1);
    // Edges counted including the accepting edge.
    chk("lit_latency", cyc - acc_cyc + 1, N);
    chk("lit_class", out_class, c);
    chk("lit_score", out_score, s);
    chk("lit_tie", out_tie, t);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("stall_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_outputs", {out_class, out_score, out_tie}, {IW'(c), SW'(s), t[0]});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int budget;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_scores = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("lit_reset_ready", in_ready, 1);
    chk("lit_reset_outs", {out_valid, out_class, out_score, out_tie}, 0);

    send(pack5(1, 0, 2, 1, 3));
    expect_result(4, 3, 0, 0);

    send(pack5(2, 2, 2, 2, 2));
    expect_result(0, 2, 1, 0);

    send(pack5(0, 3, 1, 3, 0));
    expect_result(1, 3, 1, 3);

    // New vector offered mid-scan must be ignored.
    send(pack5(0, 1, 0, 2, 1));
    in_scores = pack5(3, 3, 3, 3, 3);
    in_valid  = 1'b1;
    repeat (2) @(posedge clk);
    #1 in_valid = 1'b0;
    expect_result(3, 2, 0, 0);

    // Reset during the second scan cycle aborts silently.
    send(pack5(1, 2, 3, 0, 1));
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("lit_midscan_rst_ready", in_ready, 1);
    chk("lit_midscan_rst_valid", out_valid, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    send(pack5(3, 0, 0, 0, 0));
    expect_result(0, 3, 0, 0);

    // Back-to-back with the consumer always ready.
    @(posedge clk); #1;
    out_ready = 1'b1;
    b2b_chk   = 1'b1;
    prev_acc  = -1;
    send(pack5(2, 1, 0, 3, 3));
    send(pack5(0, 0, 0, 0, 1));
    send(pack5(1, 1, 0, 0, 0));
    budget = 50;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    chk("drain_wait", budget > 0, 1);
    chk("lit_b2b_last", last_res, {IW'(0), SW'(1), 1'b1});
    b2b_chk   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
